// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM states, 2-bit opcodes and
// the button one-hot to opcode mapping.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_OPA = 2'd0,
        S_OPB = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    function automatic logic is_onehot(input logic [3:0] code);
        return (code != 4'd0) && ((code & (code - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful when is_onehot(code) holds.
    function automatic logic [1:0] onehot_to_op(input logic [3:0] code);
        case (code)
            4'b1000: return OP_ADD;
            4'b0100: return OP_SUB;
            4'b0010: return OP_AND;
            default: return OP_OR;
        endcase
    endfunction

endpackage

// File: rtl/press_detect.sv
// Rising-edge detector for a synchronized button level; history resets high so
// a button held through reset release never produces a pulse.
module press_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_q <= 1'b1;
        else       level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_sequencer.sv
// Four-step operand/opcode/result sequencer driving an external combinational
// ALU. Define ALU_SEQ_ACCUM_EN to chain the result into operand A from S_RES.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       op_onehot,
    input  logic             op_active,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       state,
    output logic             result_valid
);

    state_t state_q, state_d;
    logic   press;
    logic   op_sel;
    logic   ld_a, ld_b, ld_op, ld_res, ld_acc, clr_sel;

    press_detect u_press (
        .clk   (clk),
        .reset (reset),
        .level (enter),
        .pulse (press)
    );

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        ld_res  = 1'b0;
        ld_acc  = 1'b0;
        clr_sel = 1'b0;
        case (state_q)
            S_OPA: if (press) begin
                ld_a    = 1'b1;
                state_d = S_OPB;
            end
            S_OPB: if (press) begin
                ld_b    = 1'b1;
                state_d = S_OP;
            end
            S_OP: begin
                ld_op = op_active && is_onehot(op_onehot);
                // op_sel is the registered flag, so a same-cycle selection
                // does not qualify this press.
                if (press && op_sel) begin
                    ld_res  = 1'b1;
                    state_d = S_RES;
                end
            end
            S_RES: if (press) begin
                clr_sel = 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
                ld_acc  = 1'b1;
                state_d = S_OPB;
`else
                state_d = S_OPA;
`endif
            end
            default: state_d = S_OPA;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OPA;
            op_a    <= '0;
            op_b    <= '0;
            alu_op  <= OP_ADD;
            result  <= '0;
            op_sel  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_a)        op_a <= data_in;
            else if (ld_acc) op_a <= result;
            if (ld_b)   op_b   <= data_in;
            if (ld_op)  alu_op <= onehot_to_op(op_onehot);
            if (ld_res) result <= alu_result;
            if (clr_sel)    op_sel <= 1'b0;
            else if (ld_op) op_sel <= 1'b1;
        end
    end

    assign state        = state_q;
    assign result_valid = (state_q == S_RES);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: stimulus queues expected results, a
// monitor checks each result on result_valid rising; state checks are inline.
module tb_alu_sequencer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enter;
    logic [WIDTH-1:0] data_in;
    logic [3:0]       op_onehot;
    logic             op_active;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] op_a, op_b, result;
    logic [1:0]       alu_op, state;
    logic             result_valid;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [1:0]       op;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enter        (enter),
        .data_in      (data_in),
        .op_onehot    (op_onehot),
        .op_active    (op_active),
        .alu_result   (alu_result),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_op       (alu_op),
        .result       (result),
        .state        (state),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // External ALU the sequencer drives
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = op_a + op_b;
            2'b01:   alu_result = op_a - op_b;
            2'b10:   alu_result = op_a & op_b;
            default: alu_result = op_a | op_b;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    task automatic sel_op(input logic [3:0] code);
        op_onehot = code;
        op_active = 1'b1;
        step();
        op_active = 1'b0;
        op_onehot = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Scoreboard monitor
    initial begin
        logic rv_prev;
        exp_t e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !rv_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got 0x%0h with no expected entry", result);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, 32'(result), 32'(e.res));
                    chk({e.name, "_alu_op"}, 32'(alu_op), 32'(e.op));
                end
            end
            rv_prev = result_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        enter     = 1'b0;
        data_in   = '0;
        op_onehot = 4'b0000;
        op_active = 1'b0;
        repeat (2) step();
        chk("rst_state", 32'(state), 0);
        chk("rst_op_a", 32'(op_a), 0);
        chk("rst_op_b", 32'(op_b), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_valid", 32'(result_valid), 0);
        reset = 1'b0;
        step();

        // 5 + 3
        data_in = 16'd5; press();
        chk("add_opb_state", 32'(state), 1);
        chk("add_op_a", 32'(op_a), 5);
        data_in = 16'd3; press();
        chk("add_op_state", 32'(state), 2);
        chk("add_op_b", 32'(op_b), 3);
        sel_op(4'b1000);
        chk("add_sel_alu_op", 32'(alu_op), 0);
        sb.push_back('{16'd8, 2'b00, "add_5_3"});
        press();
        chk("add_res_state", 32'(state), 3);
        chk("add_res_valid", 32'(result_valid), 1);
        sel_op(4'b0001);
        chk("op_ignored_in_res", 32'(alu_op), 0);
`ifdef ALU_SEQ_ACCUM_EN
        press();
        chk("acc_state", 32'(state), 1);
        chk("acc_op_a", 32'(op_a), 8);
        data_in = 16'd2; press();
        sel_op(4'b1000);
        sb.push_back('{16'd10, 2'b00, "acc_8_2"});
        press();
        chk("acc_res_state", 32'(state), 3);
        chk("acc_result", 32'(result), 10);
`else
        press();
        chk("res_to_opa_state", 32'(state), 0);
        chk("res_retained", 32'(result), 8);
        chk("op_a_retained", 32'(op_a), 5);
        chk("valid_cleared", 32'(result_valid), 0);
`endif
        do_reset();

        // 3 - 5 wraps
        data_in = 16'd3; press();
        data_in = 16'd5; press();
        sel_op(4'b0100);
        sb.push_back('{16'hFFFE, 2'b01, "sub_3_5"});
        press();
        chk("sub_res_state", 32'(state), 3);

        // Presses without a prior valid opcode are discarded
`ifdef ALU_SEQ_ACCUM_EN
        press();
`else
        press();
        data_in = 16'd7; press();
`endif
        chk("nop_opb_state", 32'(state), 1);
        data_in = 16'd2; press();
        chk("nop_op_state", 32'(state), 2);
        press();
        chk("nop_press_state", 32'(state), 2);
        op_onehot = 4'b1100; op_active = 1'b1; enter = 1'b1;
        step();
        op_active = 1'b0; op_onehot = 4'b0000; enter = 1'b0;
        step();
        chk("multi_hot_state", 32'(state), 2);
        chk("multi_hot_alu_op", 32'(alu_op), 1);
        op_onehot = 4'b0010; step(); op_onehot = 4'b0000;
        press();
        chk("inactive_op_state", 32'(state), 2);
        chk("inactive_op_alu_op", 32'(alu_op), 1);
        sel_op(4'b0010);
        chk("and_alu_op", 32'(alu_op), 2);
        sb.push_back('{16'd2, 2'b10, "and_x_2"});
        press();
        chk("and_res_state", 32'(state), 3);

        // Held enter yields a single press
        do_reset();
        data_in = 16'h1234;
        enter = 1'b1;
        repeat (10) step();
        chk("hold_state", 32'(state), 1);
        chk("hold_op_a", 32'(op_a), 32'h1234);

        // Async reset mid-cycle in S_OPB, enter held through release
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_op_a", 32'(op_a), 0);
        chk("mid_rst_valid", 32'(result_valid), 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("rst_release_no_press", 32'(state), 0);
        enter = 1'b0;
        step();

        // 0x00F0 | 0x0F0F
        data_in = 16'h00F0; press();
        data_in = 16'h0F0F; press();
        sel_op(4'b0001);
        chk("or_alu_op", 32'(alu_op), 3);
        sb.push_back('{16'h0FFF, 2'b11, "or_f0_f0f"});
        press();
        chk("or_res_state", 32'(state), 3);

        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enter  input  1  confirm button level, already synchronized to clk.
REQ-005 SHALL have port data_in  input  WIDTH  switch operand value.
REQ-006 SHALL have port op_onehot  input  4  operation code from the button combiner: 1000 add, 0100 sub, 0010 and, 0001 or.
REQ-007 SHALL have port op_active  input  1  high while op_onehot holds a live combination.
REQ-008 SHALL have port alu_result  input  WIDTH  combinational ALU output for op_a, op_b, alu_op.
REQ-009 SHALL have port op_a  output  WIDTH  registered operand A.
REQ-010 SHALL have port op_b  output  WIDTH  registered operand B.
REQ-011 SHALL have port alu_op  output  2  registered opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-012 SHALL have port result  output  WIDTH  captured result.
REQ-013 SHALL have port state  output  2  current state for LEDs: 0 S_OPA, 1 S_OPB, 2 S_OP, 3 S_RES.
REQ-014 SHALL have port result_valid  output  1  high exactly while in S_RES.

Function
REQ-015 SHALL register enter into enter_q each cycle; press = enter & ~enter_q; holding enter any number of cycles SHALL yield one press.
REQ-016 SHALL implement the FSM S_OPA -> S_OPB -> S_OP -> S_RES -> S_OPA, advancing only on press.
REQ-017 In S_OPA, press SHALL load op_a <= data_in and go to S_OPB.
REQ-018 In S_OPB, press SHALL load op_b <= data_in and go to S_OP.
REQ-019 In S_OP, a cycle with op_active=1 and op_onehot exactly one-hot SHALL load alu_op (encoding per REQ-011) and set internal flag op_sel; non-one-hot codes SHALL be ignored.
REQ-020 In S_OP, press SHALL take effect only if op_sel was already set before that edge; otherwise the press is discarded and the state stays S_OP.
REQ-021 On the accepted press leaving S_OP, result SHALL load alu_result on that same edge; result_valid SHALL be 1 from the next cycle.
REQ-022 Arithmetic SHALL be WIDTH-bit modulo (sub wraps; no carry/borrow output); the block itself performs no arithmetic.
REQ-023 In S_RES, press SHALL go to S_OPA, clear op_sel; op_a, op_b, alu_op, result retain values until overwritten.
REQ-024 op_onehot changes outside S_OP SHALL have no effect.

Reset
REQ-025 Reset SHALL force state S_OPA, op_a/op_b/result 0, alu_op 00, op_sel 0, result_valid 0.
REQ-026 Reset SHALL set enter_q to 1 so a button held through reset release generates no press.
REQ-027 Reset mid-operation SHALL abandon the sequence without capturing any value.

Configuration
REQ-028 Macro ALU_SEQ_ACCUM_EN defined: press in S_RES SHALL load op_a <= result, clear op_sel, go to S_OPB (chained operation).
REQ-029 Macro ALU_SEQ_ACCUM_EN undefined: S_RES behaviour per REQ-023.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the state enum, the 2-bit opcode constants and the one-hot-to-opcode mapping function.
REQ-031 Edge detection SHALL be sub-module press_detect (ports clk, reset, level, pulse; reset value of history 1).

Verification
REQ-032 A=5, B=3, op_onehot 1000, press -> alu_op 00, result 8, result_valid 1, state 3.
REQ-033 A=3, B=5, op_onehot 0100, press -> alu_op 01, result 0xFFFE.
REQ-034 In S_OP press with no prior op, then op_onehot 1100 and press -> state stays 2, alu_op unchanged.
REQ-035 enter held high 10 cycles in S_OPA -> exactly one transition to S_OPB.
REQ-036 Reset asserted in S_OPB with op_a=0x1234 -> immediately state 0, op_a 0, result_valid 0; enter high through release gives no press.
REQ-037 With ALU_SEQ_ACCUM_EN: result 8, press, B=2, op 1000, press -> state 3, result 10.
